cpu_debug_sampler: RTL and testbench

//  Upstream feeder of the board LED/7-seg display stage. Samples live NES CPU state (PC, SP, IR, P)
//  at a human-readable rate, freezes the display on a key press, and stops the CPU on a PC

---
 rtl/cpu_debug_sampler_pkg.sv | 31 +++
 rtl/cpu_debug_sampler_key_debounce.sv | 58 +++++
 rtl/cpu_debug_sampler.sv | 167 ++++++++++++++++
 tb/tb_cpu_debug_sampler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_sampler_pkg.sv
// Shared types and default constants for the CPU debug sampler.
// The sampler feeds held CPU register values to the board display stage.
package cpu_debug_sampler_pkg;

    localparam int unsigned SAMPLE_DIV_DEF   = 2_500_000;
    localparam int unsigned DEBOUNCE_CYC_DEF = 500_000;

    localparam int unsigned PC_W  = 16;
    localparam int unsigned REG_W = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BREAK = 2'd2,
        ST_STEP  = 2'd3
    } state_e;

    // Snapshot of the CPU registers shown on the display.
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [REG_W-1:0] sp;
        logic [REG_W-1:0] ir;
        logic [REG_W-1:0] p;
    } cpu_regs_t;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_debug_sampler_key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on the debounced 1->0 edge (keys are active-low).
module cpu_debug_sampler_key_debounce
    import cpu_debug_sampler_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_key_raw,
    output logic o_press
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive cycles the synchronised key differs from the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_key_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/cpu_debug_sampler.sv
// Samples live CPU state at a display-friendly rate, freezes on a key press,
// and halts the CPU on a PC breakpoint with single-instruction stepping.
module cpu_debug_sampler
    import cpu_debug_sampler_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = SAMPLE_DIV_DEF,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [PC_W-1:0]   i_nes_cpu_pc,
    input  logic [REG_W-1:0]  i_nes_cpu_sp,
    input  logic [REG_W-1:0]  i_nes_cpu_ir,
    input  logic [REG_W-1:0]  i_nes_cpu_p,
    input  logic              i_cpu_sync,
    input  logic              i_key_hold,
    input  logic              i_key_step,
    input  logic              i_bp_en,
    input  logic [PC_W-1:0]   i_bp_addr,
    output logic [PC_W-1:0]   o_nes_cpu_pc,
    output logic [REG_W-1:0]  o_nes_cpu_sp,
    output logic [REG_W-1:0]  o_nes_cpu_ir,
    output logic [REG_W-1:0]  o_nes_cpu_p,
    output logic              o_cpu_halt,
    output logic [1:0]        o_state,
    output logic              o_bp_hit
);

    localparam int unsigned TW = cnt_width(SAMPLE_DIV);

    logic          hold_press_c;
    logic          step_press_c;
    logic          tick_c;
    logic          bp_match_c;
    cpu_regs_t     live_c;

    state_e        state_q;
    state_e        state_d;
    cpu_regs_t     held_q;
    cpu_regs_t     held_d;
    logic          halt_q;
    logic          halt_d;
    logic          bp_hit_q;
    logic          bp_hit_d;
    logic          armed_q;
    logic          armed_d;
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;

    cpu_debug_sampler_key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_hold (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_key_raw (i_key_hold),
        .o_press   (hold_press_c)
    );

    cpu_debug_sampler_key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_step (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_key_raw (i_key_step),
        .o_press   (step_press_c)
    );

    // Live register bundle, sample tick and breakpoint compare.
    always_comb begin
        live_c.pc  = i_nes_cpu_pc;
        live_c.sp  = i_nes_cpu_sp;
        live_c.ir  = i_nes_cpu_ir;
        live_c.p   = i_nes_cpu_p;
        tick_c     = (tick_cnt_q == TW'(SAMPLE_DIV - 1));
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TW'(1);
        bp_match_c = i_bp_en & armed_q & i_cpu_sync & (i_nes_cpu_pc == i_bp_addr);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        halt_d   = halt_q;
        bp_hit_d = 1'b0;
        armed_d  = armed_q;

        // Re-arm only once the CPU has fetched somewhere other than the breakpoint.
        if (i_cpu_sync && (i_nes_cpu_pc != i_bp_addr)) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                halt_d = 1'b0;
                if (bp_match_c) begin
                    held_d   = live_c;
                    bp_hit_d = 1'b1;
                    halt_d   = 1'b1;
                    state_d  = ST_BREAK;
                end else begin
                    if (tick_c) begin
                        held_d = live_c;
                    end
                    if (hold_press_c) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                halt_d = 1'b0;
                if (hold_press_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_BREAK: begin
                halt_d = 1'b1;
                if (hold_press_c) begin
                    state_d = ST_RUN;
                    halt_d  = 1'b0;
                    armed_d = 1'b0;
                end else if (step_press_c) begin
                    state_d = ST_STEP;
                    halt_d  = 1'b0;
                end
            end
            ST_STEP: begin
                halt_d = 1'b0;
                if (i_cpu_sync) begin
                    held_d  = live_c;
                    halt_d  = 1'b1;
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_RUN;
                halt_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_RUN;
            held_q     <= '0;
            halt_q     <= 1'b0;
            bp_hit_q   <= 1'b0;
            armed_q    <= 1'b1;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            halt_q     <= halt_d;
            bp_hit_q   <= bp_hit_d;
            armed_q    <= armed_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign o_nes_cpu_pc = held_q.pc;
    assign o_nes_cpu_sp = held_q.sp;
    assign o_nes_cpu_ir = held_q.ir;
    assign o_nes_cpu_p  = held_q.p;
    assign o_cpu_halt   = halt_q;
    assign o_state      = state_q;
    assign o_bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_cpu_debug_sampler.sv
// Directed bench for cpu_debug_sampler with SAMPLE_DIV=4 and DEBOUNCE_CYC=8.
module tb_cpu_debug_sampler;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_in;
    logic [7:0]  sp_in;
    logic [7:0]  ir_in;
    logic [7:0]  p_in;
    logic        sync_in;
    logic        key_hold;
    logic        key_step;
    logic        bp_en;
    logic [15:0] bp_addr;
    logic [15:0] o_pc;
    logic [7:0]  o_sp;
    logic [7:0]  o_ir;
    logic [7:0]  o_p;
    logic        o_halt;
    logic [1:0]  o_state;
    logic        o_bp_hit;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        ramp   = 1'b0;

    cpu_debug_sampler #(
        .SAMPLE_DIV   (4),
        .DEBOUNCE_CYC (8)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .i_nes_cpu_pc (pc_in),
        .i_nes_cpu_sp (sp_in),
        .i_nes_cpu_ir (ir_in),
        .i_nes_cpu_p  (p_in),
        .i_cpu_sync   (sync_in),
        .i_key_hold   (key_hold),
        .i_key_step   (key_step),
        .i_bp_en      (bp_en),
        .i_bp_addr    (bp_addr),
        .o_nes_cpu_pc (o_pc),
        .o_nes_cpu_sp (o_sp),
        .o_nes_cpu_ir (o_ir),
        .o_nes_cpu_p  (o_p),
        .o_cpu_halt   (o_halt),
        .o_state      (o_state),
        .o_bp_hit     (o_bp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [15:0] exp_pc;
        logic [7:0]  exp_sp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: edge, settle, then advance the ramp for the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (ramp) pc_in = pc_in + 16'd1;
    endtask

    // Press a key until o_state reaches tgt (bounded), then release and let it settle.
    task automatic press_until(input bit use_step, input logic [1:0] tgt, input string name);
        if (use_step) key_step = 1'b0; else key_hold = 1'b0;
        for (int n = 0; n < 20 && o_state != tgt; n++) cyc();
        check(name, 32'(o_state), 32'(tgt));
        if (use_step) key_step = 1'b1; else key_hold = 1'b1;
    endtask

    logic [15:0] frozen;
    bit          changed;

    initial begin
        vecs[0] = '{16'h8000, 8'h00, 16'h0000, 8'h00};
        vecs[1] = '{16'h8001, 8'h01, 16'h0000, 8'h00};
        vecs[2] = '{16'h8002, 8'h02, 16'h0000, 8'h00};
        vecs[3] = '{16'h8003, 8'h03, 16'h8003, 8'h03};
        vecs[4] = '{16'h8004, 8'h04, 16'h8003, 8'h03};
        vecs[5] = '{16'h8005, 8'h05, 16'h8003, 8'h03};
        vecs[6] = '{16'h8006, 8'h06, 16'h8003, 8'h03};
        vecs[7] = '{16'h8007, 8'h07, 16'h8007, 8'h07};
        vecs[8] = '{16'h8008, 8'h08, 16'h8007, 8'h07};
        vecs[9] = '{16'h8009, 8'h09, 16'h8007, 8'h07};

        rst_n    = 1'b0;
        pc_in    = 16'h0;
        sp_in    = 8'h0;
        ir_in    = 8'hA9;
        p_in     = 8'h24;
        sync_in  = 1'b0;
        key_hold = 1'b1;
        key_step = 1'b1;
        bp_en    = 1'b0;
        bp_addr  = 16'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", 32'(o_pc), 32'h0);
        check("reset_state", 32'(o_state), 32'd0);
        check("reset_halt", 32'(o_halt), 32'd0);
        check("reset_bp_hit", 32'(o_bp_hit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sampling: outputs follow live values only on every 4th edge
        for (int i = 0; i < 10; i++) begin
            pc_in = vecs[i].pc;
            sp_in = vecs[i].sp;
            cyc();
            check($sformatf("tick_pc[%0d]", i), 32'(o_pc), 32'(vecs[i].exp_pc));
            check($sformatf("tick_sp[%0d]", i), 32'(o_sp), 32'(vecs[i].exp_sp));
        end
        check("tick_ir", 32'(o_ir), 32'hA9);
        check("tick_p", 32'(o_p), 32'h24);

        // Bounce shorter than debounce window gives no state change
        ramp = 1'b1;
        changed = 1'b0;
        key_hold = 1'b0;
        repeat (3) cyc();
        key_hold = 1'b1;
        for (int n = 0; n < 14; n++) begin
            cyc();
            if (o_state != 2'd0) changed = 1'b1;
        end
        check("bounce_no_change", 32'(changed), 32'd0);

        // Hold freezes outputs while the CPU keeps running
        press_until(1'b0, 2'd1, "enter_hold");
        frozen = o_pc;
        repeat (12) cyc();
        check("hold_frozen_pc", 32'(o_pc), 32'(frozen));
        check("hold_state", 32'(o_state), 32'd1);
        check("hold_halt", 32'(o_halt), 32'd0);
        press_until(1'b0, 2'd0, "leave_hold");
        repeat (12) cyc();
        checks++;
        if (o_pc === frozen) begin
            errors++;
            $display("FAIL run_resumes_sampling: got 0x%0h, required a value other than 0x%0h", o_pc, frozen);
        end

        // Breakpoint capture
        ramp    = 1'b0;
        bp_en   = 1'b1;
        bp_addr = 16'hC004;
        pc_in   = 16'hC000;
        cyc();
        pc_in   = 16'hC004;
        sp_in   = 8'hFD;
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        check("bp_state", 32'(o_state), 32'd2);
        check("bp_halt", 32'(o_halt), 32'd1);
        check("bp_pc", 32'(o_pc), 32'hC004);
        check("bp_sp", 32'(o_sp), 32'hFD);
        check("bp_hit_pulse", 32'(o_bp_hit), 32'd1);
        pc_in = 16'h1234;
        cyc();
        check("bp_hit_one_cycle", 32'(o_bp_hit), 32'd0);
        repeat (6) cyc();
        check("break_no_tick_update", 32'(o_pc), 32'hC004);
        check("break_halt_held", 32'(o_halt), 32'd1);

        // Single step
        press_until(1'b1, 2'd3, "enter_step");
        check("step_halt_low", 32'(o_halt), 32'd0);
        repeat (3) cyc();
        check("step_waits_sync", 32'(o_state), 32'd3);
        pc_in   = 16'hC006;
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        check("step_back_to_break", 32'(o_state), 32'd2);
        check("step_halt_high", 32'(o_halt), 32'd1);
        check("step_pc", 32'(o_pc), 32'hC006);
        check("step_no_bp_hit", 32'(o_bp_hit), 32'd0);
        repeat (12) cyc();

        // Resume disarms until a different PC is fetched
        press_until(1'b0, 2'd0, "resume_run");
        check("resume_halt_low", 32'(o_halt), 32'd0);
        repeat (12) cyc();
        pc_in   = 16'hC004;
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        check("no_rebreak_state", 32'(o_state), 32'd0);
        check("no_rebreak_hit", 32'(o_bp_hit), 32'd0);
        pc_in   = 16'hC005;
        sync_in = 1'b1;
        cyc();
        pc_in   = 16'hC004;
        cyc();
        sync_in = 1'b0;
        check("rearm_break_state", 32'(o_state), 32'd2);
        check("rearm_break_pc", 32'(o_pc), 32'hC004);
        check("rearm_bp_hit", 32'(o_bp_hit), 32'd1);

        // Asynchronous reset during BREAK
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_halt", 32'(o_halt), 32'd0);
        check("async_rst_pc", 32'(o_pc), 32'h0);
        check("async_rst_state", 32'(o_state), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("post_rst_state", 32'(o_state), 32'd0);
        check("post_rst_halt", 32'(o_halt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
